// File: rtl/sram_stream_loader.sv
// SRAM-to-array row loader: fetches a tile of rows word by word, packs each row
// little-endian into a lane vector and streams rows out through a small FIFO.
module sram_stream_loader #(
    parameter int unsigned SRAM_W     = 32,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned LANES      = 8,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_ROWS   = 255
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   num_rows,
    output logic                            ren,
    output logic [ADDR_W-1:0]               addr,
    input  logic [SRAM_W-1:0]               rdata,
    input  logic [1:0]                      sram_state,
    output logic [LANES*LANE_W-1:0]         out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned RowW = LANES * LANE_W;
    localparam int unsigned Wpr  = RowW / SRAM_W;
    localparam int unsigned CntW = $clog2(MAX_ROWS + 1);
    localparam int unsigned FcW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned IdxW = (Wpr > 1) ? $clog2(Wpr) : 1;

    localparam logic [FcW-1:0]  FifoFull = FcW'(FIFO_DEPTH);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(Wpr - 1);
    localparam logic [1:0]      SramAccess = 2'd2;
    localparam logic [1:0]      SramError  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSpace,
        StRead,
        StPush,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CntW-1:0]   rows_left_q, rows_left_d;
    logic [IdxW-1:0]   word_idx_q, word_idx_d;
    logic              err_q, err_d;
    logic              ren_q;
    logic              asm_we;
    logic [RowW-1:0]   asm_q;

    logic [RowW-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FcW-1:0]    count_q, count_after;
    logic              push, pop;

    assign push        = (state_q == StPush);
    assign pop         = out_valid && out_ready;
    assign count_after = count_q + FcW'(push) - FcW'(pop);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rows_left_d = rows_left_q;
        word_idx_d  = word_idx_q;
        err_d       = err_q;
        asm_we      = 1'b0;
        case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    rows_left_d = num_rows;
                    word_idx_d  = '0;
                    err_d       = 1'b0;
                    if (num_rows == '0) begin
                        state_d = StDone;
                    end else if (count_q < FifoFull) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWaitSpace;
                    end
                end
            end
            StWaitSpace: begin
                if (count_q < FifoFull) state_d = StRead;
            end
            StRead: begin
                if (sram_state == SramAccess) begin
                    asm_we     = 1'b1;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    if (word_idx_q == LastIdx) begin
                        state_d = StPush;
                    end else begin
                        word_idx_d = word_idx_q + IdxW'(1);
                    end
                end else if (sram_state == SramError) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end
            end
            StPush: begin
                rows_left_d = rows_left_q - CntW'(1);
                word_idx_d  = '0;
                if (rows_left_q == CntW'(1)) begin
                    state_d = StDone;
                end else if (count_after < FifoFull) begin
                    state_d = StRead;
                end else begin
                    state_d = StWaitSpace;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over start and every transition; err is left as it was.
        if (abort) begin
            state_d    = StIdle;
            word_idx_d = '0;
            err_d      = err_q;
            asm_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            rows_left_q <= '0;
            word_idx_q  <= '0;
            err_q       <= 1'b0;
            ren_q       <= 1'b0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rows_left_q <= rows_left_d;
            word_idx_q  <= word_idx_d;
            err_q       <= err_d;
            ren_q       <= (state_d == StRead);
            if (asm_we) begin
                for (int w = 0; w < int'(Wpr); w++) begin
                    if (word_idx_q == IdxW'(w)) asm_q[w*SRAM_W +: SRAM_W] <= rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= asm_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_after;
        end
    end

    assign ren        = ren_q;
    assign addr       = cur_addr_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign out_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign out_data   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed bench for sram_stream_loader: cycle table for a basic tile plus
// sequences for back-pressure, SRAM waits/errors, abort, reset, wrap and WPR=4.
module tb_sram_stream_loader;

    logic        clk;
    logic        n_rst;
    logic        start, abort, out_ready;
    logic [9:0]  base_addr;
    logic [7:0]  num_rows;
    logic        ren, out_valid, busy, done, err;
    logic [9:0]  addr;
    logic [31:0] rdata;
    logic [1:0]  sram_state;
    logic [63:0] out_data;
    logic [2:0]  fifo_count;

    logic         start4, abort4, out_ready4;
    logic [9:0]   base4;
    logic [7:0]   num_rows4;
    logic         ren4, out_valid4, busy4, done4, err4;
    logic [9:0]   addr4;
    logic [31:0]  rdata4;
    logic [1:0]   sram_state4;
    logic [127:0] out_data4;
    logic [1:0]   fifo_count4;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done4_cnt = 0;

    // SRAM model knobs
    int         n_busy;
    logic       err_en;
    logic [9:0] err_addr, tile_base;
    int         wait_cnt;
    logic [9:0] diff, diff4;

    sram_stream_loader dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .base_addr(base_addr),
        .num_rows(num_rows), .ren(ren), .addr(addr), .rdata(rdata), .sram_state(sram_state),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err), .fifo_count(fifo_count)
    );

    sram_stream_loader #(.LANES(16), .FIFO_DEPTH(2)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .abort(abort4), .base_addr(base4),
        .num_rows(num_rows4), .ren(ren4), .addr(addr4), .rdata(rdata4),
        .sram_state(sram_state4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready4), .busy(busy4), .done(done4), .err(err4),
        .fifo_count(fifo_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int k);
        logic [31:0] w;
        int t;
        for (int b = 0; b < 4; b++) begin
            t = 4 * k + b;
            w[b*8 +: 8] = 8'(t);
        end
        return w;
    endfunction

    function automatic logic [127:0] exp_row(input int r, input int wpr);
        logic [127:0] v;
        v = '0;
        for (int w = 0; w < wpr; w++) v[w*32 +: 32] = word_of(r * wpr + w);
        return v;
    endfunction

    assign diff   = addr - tile_base;
    assign diff4  = addr4 - base4;
    assign rdata  = word_of(int'(diff));
    assign rdata4 = word_of(int'(diff4));
    assign sram_state4 = ren4 ? 2'd2 : 2'd0;

    always_comb begin
        sram_state = 2'd0;
        if (ren) begin
            if (wait_cnt < n_busy) sram_state = 2'd1;
            else if (err_en && addr == err_addr) sram_state = 2'd3;
            else sram_state = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (ren && sram_state == 2'd1) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (done) done_cnt <= done_cnt + 1;
        if (done4) done4_cnt <= done4_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic collect(input int nrows, input int budget);
        int r = 0;
        for (int c = 0; c < budget && r < nrows; c++) begin
            if (out_valid && out_ready) begin
                check($sformatf("row%0d_data", r), out_data, exp_row(r, 2));
                r++;
            end
            @(negedge clk);
        end
        check("rows_received", r, nrows);
    endtask

    task automatic collect4(input int nrows, input int budget);
        int r = 0;
        for (int c = 0; c < budget && r < nrows; c++) begin
            if (out_valid4 && out_ready4) begin
                check($sformatf("wpr4_row%0d_data", r), out_data4, exp_row(r, 4));
                r++;
            end
            @(negedge clk);
        end
        check("wpr4_rows_received", r, nrows);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ren"}, ren, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        ren;
        logic [9:0]  addr;
        logic        done;
        logic        busy;
        logic        valid;
        logic [2:0]  count;
        logic [63:0] data;
    } vec_t;

    vec_t vec [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, n_addr, r, hit;
        logic [9:0] exp_a;
        logic [9:0] wrap_exp [4];
        logic ren_seen;

        vec[0]  = '{1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 10'h011, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 10'h012, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 10'h012, 1'b0, 1'b1, 1'b1, 3'd1, 64'h0706050403020100};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 10'h013, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[6]  = '{1'b0, 1'b1, 1'b0, 10'h014, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 10'h014, 1'b0, 1'b1, 1'b1, 3'd1, 64'h0F0E0D0C0B0A0908};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 10'h015, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 10'h016, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vec[10] = '{1'b0, 1'b1, 1'b0, 10'h016, 1'b1, 1'b1, 1'b1, 3'd1, 64'h1716151413121110};
        vec[11] = '{1'b0, 1'b1, 1'b0, 10'h016, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0};
        wrap_exp[0] = 10'h3FE;
        wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000;
        wrap_exp[3] = 10'h001;

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; num_rows = '0; n_busy = 0; err_en = 1'b0; err_addr = '0;
        tile_base = '0;
        start4 = 1'b0; abort4 = 1'b0; out_ready4 = 1'b0; base4 = '0; num_rows4 = '0;
        step(3);
        check_reset_outputs("reset");
        n_rst = 1'b1;

        // Basic tile, cycle-accurate table
        base_addr = 10'h010; tile_base = 10'h010; num_rows = 8'd3;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("c%0d_ren", i), ren, vec[i].ren);
            check($sformatf("c%0d_addr", i), addr, vec[i].addr);
            check($sformatf("c%0d_done", i), done, vec[i].done);
            check($sformatf("c%0d_busy", i), busy, vec[i].busy);
            check($sformatf("c%0d_valid", i), out_valid, vec[i].valid);
            check($sformatf("c%0d_count", i), fifo_count, vec[i].count);
            if (vec[i].valid) check($sformatf("c%0d_data", i), out_data, vec[i].data);
            start = vec[i].start;
            out_ready = vec[i].ready;
            step(1);
        end
        start = 1'b0;

        // Back-pressure: FIFO fills, reads stall, start is ignored while busy
        base_addr = 10'h020; tile_base = 10'h020; num_rows = 8'd6; out_ready = 1'b0;
        d0 = done_cnt;
        start = 1'b1; step(1); start = 1'b0;
        step(20);
        check("bp_count_full", fifo_count, 4);
        check("bp_busy", busy, 1);
        check("bp_ren_idle", ren, 0);
        base_addr = 10'h300; num_rows = 8'd1; start = 1'b1; step(1); start = 1'b0;
        ren_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (ren) ren_seen = 1'b1;
            step(1);
        end
        check("bp_no_read_while_full", ren_seen, 0);
        check("bp_count_held", fifo_count, 4);
        out_ready = 1'b1;
        collect(6, 200);
        step(2);
        check("bp_done_once", done_cnt - d0, 1);
        check("bp_idle_after", busy, 0);
        check("bp_empty_after", fifo_count, 0);

        // SRAM waits then ERROR on row 2 word 1
        base_addr = 10'h040; tile_base = 10'h040; num_rows = 8'd4; out_ready = 1'b0;
        n_busy = 2; err_en = 1'b1; err_addr = 10'h045;
        d0 = done_cnt;
        start = 1'b1; step(1); start = 1'b0;
        exp_a = 10'h040; hit = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            if (ren) begin
                check("wait_addr_stable", addr, exp_a);
                if (sram_state == 2'd2) exp_a = exp_a + 10'd1;
                else if (sram_state == 2'd3) hit = 1;
            end
            if (hit == 0) step(1);
        end
        check("error_reached", hit, 1);
        step(1);
        check("error_err_set", err, 1);
        check("error_ren_drop", ren, 0);
        check("error_busy", busy, 1);
        check("error_rows_held", fifo_count, 2);
        step(3);
        check("error_hold_ren", ren, 0);
        out_ready = 1'b1;
        collect(2, 20);
        check("error_drained", fifo_count, 0);
        check("error_no_done", done_cnt - d0, 0);
        check("error_err_sticky", err, 1);
        out_ready = 1'b0;
        abort = 1'b1; step(1); abort = 1'b0;
        check("abort_from_err_idle", busy, 0);
        check("abort_keeps_err", err, 1);
        n_busy = 0; err_en = 1'b0;

        // Reset asserted during row 1 word 1
        base_addr = 10'h100; tile_base = 10'h100; num_rows = 8'd3;
        start = 1'b1; step(1); start = 1'b0;
        check("start_clears_err", err, 0);
        step(4);
        check("rst_pre_count", fifo_count, 1);
        check("rst_pre_addr", addr, 10'h103);
        n_rst = 1'b0; step(1);
        check_reset_outputs("midrst");
        n_rst = 1'b1; step(1);

        // Abort during row 1 word 1, then a fresh tile
        base_addr = 10'h080; tile_base = 10'h080; num_rows = 8'd3; d0 = done_cnt;
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        check("abort_pre_ren", ren, 1);
        check("abort_pre_addr", addr, 10'h083);
        abort = 1'b1; step(1); abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_flush", fifo_count, 0);
        check("abort_valid", out_valid, 0);
        check("abort_ren", ren, 0);
        step(5);
        check("abort_no_done", done_cnt - d0, 0);
        base_addr = 10'h0A0; tile_base = 10'h0A0; num_rows = 8'd2; out_ready = 1'b1;
        d0 = done_cnt;
        start = 1'b1; step(1); start = 1'b0;
        collect(2, 40);
        step(2);
        check("restart_done", done_cnt - d0, 1);

        // Address wrap
        base_addr = 10'h3FE; tile_base = 10'h3FE; num_rows = 8'd2; out_ready = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        n_addr = 0; r = 0;
        for (int c = 0; c < 30; c++) begin
            if (ren && sram_state == 2'd2) begin
                if (n_addr < 4) check($sformatf("wrap_addr%0d", n_addr), addr, wrap_exp[n_addr]);
                n_addr++;
            end
            if (out_valid && out_ready) begin
                check($sformatf("wrap_row%0d", r), out_data, exp_row(r, 2));
                r++;
            end
            step(1);
        end
        check("wrap_word_count", n_addr, 4);
        check("wrap_row_count", r, 2);

        // Zero-row tile
        num_rows = 8'd0; d0 = done_cnt;
        start = 1'b1; step(1); start = 1'b0;
        check("zero_done", done, 1);
        check("zero_ren", ren, 0);
        step(1);
        check("zero_done_end", done, 0);
        check("zero_idle", busy, 0);
        check("zero_done_once", done_cnt - d0, 1);

        // WPR=4, two-entry FIFO
        base4 = 10'h200; num_rows4 = 8'd3; out_ready4 = 1'b0;
        start4 = 1'b1; step(1); start4 = 1'b0;
        step(25);
        check("wpr4_count_full", fifo_count4, 2);
        check("wpr4_ren_idle", ren4, 0);
        check("wpr4_busy", busy4, 1);
        out_ready4 = 1'b1;
        collect4(3, 60);
        step(2);
        check("wpr4_done_once", done4_cnt, 1);
        check("wpr4_idle", busy4, 0);
        check("wpr4_err", err4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
